// File: rtl/textbox_scanner.sv
// Frame scanner: sweeps x/y into a textbox renderer, packs returned pixels
// MSB-first into bytes and streams them out over a valid/ready handshake.
module textbox_scanner #(
    parameter int COLS          = 8,
    parameter int CHAR_W        = 8,
    parameter int ROWS          = 16,
    parameter int PIXEL_LATENCY = 1,
    parameter int XW            = $clog2(COLS * CHAR_W),
    parameter int YW            = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    input  logic          pixel,
    output logic [7:0]    byte_data,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          byte_last,
    output logic          busy,
    output logic          done
);

    localparam int XMAX = COLS * CHAR_W - 1;
    localparam int LAT  = PIXEL_LATENCY;
    localparam int WCW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, PRESENT, DONE
    } state_t;

    state_t         state, state_n;
    logic [2:0]     bit_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           at_end;
    logic           at_xmax;
    logic           cap_en;

    assign at_xmax = (x == XW'(XMAX));
    assign at_end  = at_xmax && (y == YW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = ISSUE;
            ISSUE:   if (bit_cnt == 3'd7)
                         state_n = (LAT == 0) ? PRESENT : WAIT;
            WAIT:    if (wait_cnt == WCW'(LAT - 1)) state_n = PRESENT;
            PRESENT: if (byte_ready) state_n = at_end ? DONE : ISSUE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (state == PRESENT);
        byte_last  = (state == PRESENT) && at_end;
        busy       = (state == ISSUE) || (state == WAIT) || (state == PRESENT);
        done       = (state == DONE);
    end

    // x/y hold the last issued coordinate through WAIT and PRESENT
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    x        <= '0;
                    y        <= '0;
                    bit_cnt  <= '0;
                    wait_cnt <= '0;
                end
                ISSUE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt != 3'd7) x <= x + XW'(1);
                end
                WAIT: wait_cnt <= wait_cnt + WCW'(1);
                PRESENT: begin
                    wait_cnt <= '0;
                    if (byte_ready) begin
                        if (at_end) begin
                            x <= '0;
                            y <= '0;
                        end else if (at_xmax) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                DONE: begin
                    x <= '0;
                    y <= '0;
                end
                default: ;
            endcase
        end
    end

    // Issue strobes delayed to line up with the renderer's answer
    if (LAT == 0) begin : g_comb
        assign cap_en = (state == ISSUE);
    end else begin : g_pipe
        logic [LAT-1:0] pipe;
        always_ff @(posedge clk) begin
            if (rst) pipe <= '0;
            else     pipe <= (pipe << 1) | LAT'(state == ISSUE);
        end
        assign cap_en = pipe[LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst)         byte_data <= '0;
        else if (cap_en) byte_data <= {byte_data[6:0], pixel};
    end

endmodule
